// File: rtl/rx_fcrc_ctrl.sv
// CAN XL receive FCRC sequencer: inits/gates the FCRC engine, captures the received FCRC and reports pass/fail.
// Optional fixed-stuff check in the FCRC field: define RX_FCRC_CTRL_STUFF_CHK_EN.
module rx_fcrc_ctrl #(
    parameter int MAX_COV_BITS = 20000
) (
    input  logic        clk,
    input  logic        g_rst,
    input  logic        sample,
    input  logic        rx_bit,
    input  logic        de_stuff,
    input  logic        sof,
    input  logic        fcrc_start,
    input  logic        frame_abort,
    input  logic [31:0] crc_value,
    input  logic        result_ack,
    output logic        fcrc_init,
    output logic        fcrc_enable,
    output logic [31:0] rx_fcrc,
    output logic        result_valid,
    output logic        crc_ok,
    output logic        crc_err,
    output logic        len_err,
    output logic        stuff_err
);

    typedef enum logic [2:0] {IDLE, ACCUM, RECV, CHECK, REPORT} state_t;

    localparam logic [14:0] COV_MAX = 15'(MAX_COV_BITS);

    state_t      state, state_nxt;
    logic [14:0] cov_cnt;
    logic [5:0]  bit_cnt;
    logic [31:0] snapshot;

    logic start_frame, cov_bit, cov_last, fcrc_first, recv_bit, recv_last, stuff_bad, pass;

    // SOF restarts from IDLE/ACCUM/RECV; it is ignored while a result is pending.
    assign start_frame = sample & sof & ~frame_abort &
                         (state == IDLE || state == ACCUM || state == RECV);
    assign cov_bit     = (state == ACCUM) & sample & ~de_stuff & ~fcrc_start & ~sof;
    assign cov_last    = cov_bit & (cov_cnt == COV_MAX - 15'd1);
    assign fcrc_first  = (state == ACCUM) & sample & fcrc_start & ~sof;
    assign recv_bit    = (state == RECV) & sample & ~de_stuff & ~sof;
    assign recv_last   = recv_bit & (bit_cnt == 6'd31);
    assign pass        = (rx_fcrc == snapshot) & ~len_err & ~stuff_err;

    assign fcrc_enable = (state == ACCUM) & sample & ~fcrc_start;

`ifdef RX_FCRC_CTRL_STUFF_CHK_EN
    // A fixed stuff bit must be the complement of the last data bit shifted in.
    assign stuff_bad = (state == RECV) & sample & de_stuff & ~sof & (rx_bit == rx_fcrc[0]);
`else
    assign stuff_bad = 1'b0;
`endif

    always_ff @(posedge clk or posedge g_rst) begin
        if (g_rst) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (frame_abort)      state_nxt = IDLE;
        else if (start_frame) state_nxt = ACCUM;
        else begin
            case (state)
                ACCUM:   if (cov_last) state_nxt = CHECK;
                         else if (fcrc_first) state_nxt = RECV;
                RECV:    if (recv_last || stuff_bad) state_nxt = CHECK;
                CHECK:   state_nxt = REPORT;
                REPORT:  if (result_ack) state_nxt = IDLE;
                default: state_nxt = state;
            endcase
        end
    end

    always_ff @(posedge clk or posedge g_rst) begin
        if (g_rst) begin
            fcrc_init    <= 1'b0;
            rx_fcrc      <= '0;
            snapshot     <= '0;
            cov_cnt      <= '0;
            bit_cnt      <= '0;
            result_valid <= 1'b0;
            crc_ok       <= 1'b0;
            crc_err      <= 1'b0;
            len_err      <= 1'b0;
            stuff_err    <= 1'b0;
        end else begin
            fcrc_init <= frame_abort | start_frame;
            if (frame_abort) begin
                result_valid <= 1'b0;
                crc_ok       <= 1'b0;
                crc_err      <= 1'b0;
                len_err      <= 1'b0;
                stuff_err    <= 1'b0;
            end else if (start_frame) begin
                cov_cnt   <= '0;
                bit_cnt   <= '0;
                rx_fcrc   <= '0;
                snapshot  <= '0;
                len_err   <= 1'b0;
                stuff_err <= 1'b0;
            end else begin
                if (cov_bit)  cov_cnt <= cov_cnt + 15'd1;
                if (cov_last) len_err <= 1'b1;
                if (fcrc_first) begin
                    snapshot <= crc_value;
                    rx_fcrc  <= {31'b0, rx_bit};
                    bit_cnt  <= 6'd1;
                end
                if (recv_bit) begin
                    rx_fcrc <= {rx_fcrc[30:0], rx_bit};
                    bit_cnt <= bit_cnt + 6'd1;
                end
                if (stuff_bad) stuff_err <= 1'b1;
                if (state == CHECK) begin
                    result_valid <= 1'b1;
                    crc_ok       <= pass;
                    crc_err      <= ~pass;
                end
                if (state == REPORT && result_ack) begin
                    result_valid <= 1'b0;
                    crc_ok       <= 1'b0;
                    crc_err      <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_rx_fcrc_ctrl.sv
// Bench for rx_fcrc_ctrl: table-driven frames, a result scoreboard and hand-written corner sequences.
module tb_rx_fcrc_ctrl;

    logic        clk = 1'b0, g_rst = 1'b1;
    logic        sample = 1'b0, rx_bit = 1'b0, de_stuff = 1'b0, sof = 1'b0;
    logic        fcrc_start = 1'b0, frame_abort = 1'b0, result_ack = 1'b0;
    logic [31:0] crc_value = '0;
    logic        fcrc_init, fcrc_enable, result_valid, crc_ok, crc_err, len_err, stuff_err;
    logic [31:0] rx_fcrc;

    rx_fcrc_ctrl #(.MAX_COV_BITS(16)) dut (
        .clk(clk), .g_rst(g_rst), .sample(sample), .rx_bit(rx_bit), .de_stuff(de_stuff),
        .sof(sof), .fcrc_start(fcrc_start), .frame_abort(frame_abort), .crc_value(crc_value),
        .result_ack(result_ack), .fcrc_init(fcrc_init), .fcrc_enable(fcrc_enable),
        .rx_fcrc(rx_fcrc), .result_valid(result_valid), .crc_ok(crc_ok), .crc_err(crc_err),
        .len_err(len_err), .stuff_err(stuff_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          ncov;
        logic [31:0] crc;
        logic [31:0] word;
        int          stuff_every;
        logic        ok;
        logic        err;
        logic        len;
    } vec_t;

    typedef struct {
        logic        ok;
        logic        err;
        logic        len;
        logic [31:0] rx;
    } exp_t;

    int   tests = 0, fails = 0;
    int   en_cnt = 0;
    logic rv_q = 1'b0;
    exp_t sb[$];
    exp_t e;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // Scoreboard: each rising result_valid is matched against the oldest expected result.
    always @(negedge clk) begin
        if (fcrc_enable) en_cnt <= en_cnt + 1;
        if (result_valid && !rv_q) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_result: result_valid rose with none pending");
            end else begin
                e = sb.pop_front();
                chk("crc_ok", {31'b0, crc_ok}, {31'b0, e.ok});
                chk("crc_err", {31'b0, crc_err}, {31'b0, e.err});
                chk("len_err", {31'b0, len_err}, {31'b0, e.len});
                chk("rx_fcrc", rx_fcrc, e.rx);
            end
        end
        rv_q <= result_valid;
    end

    task automatic bit_tx(input logic b, input logic st, input logic s, input logic fs);
        sample = 1'b1; rx_bit = b; de_stuff = st; sof = s; fcrc_start = fs;
        @(posedge clk); #1;
        sample = 1'b0; de_stuff = 1'b0; sof = 1'b0; fcrc_start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    // Last frame bit: CHECK for one cycle, then result_valid.
    task automatic last_bit(input logic b, input int exp_en, input int en0);
        sample = 1'b1; rx_bit = b;
        @(posedge clk); #1;
        sample = 1'b0;
        chk("rv_during_check", {31'b0, result_valid}, 32'd0);
        @(posedge clk); #1;
        chk("rv_latency", {31'b0, result_valid}, 32'd1);
        chk("fcrc_enable_count", en_cnt - en0, exp_en);
    endtask

    task automatic ack_result(input logic ok, input logic err);
        repeat (3) @(posedge clk);
        #1;
        chk("rv_hold", {31'b0, result_valid}, 32'd1);
        chk("ok_hold", {31'b0, crc_ok}, {31'b0, ok});
        chk("err_hold", {31'b0, crc_err}, {31'b0, err});
        result_ack = 1'b1;
        @(posedge clk); #1;
        result_ack = 1'b0;
        chk("rv_after_ack", {31'b0, result_valid}, 32'd0);
        chk("ok_after_ack", {31'b0, crc_ok}, 32'd0);
        chk("err_after_ack", {31'b0, crc_err}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic run_frame(input vec_t v);
        int   en0;
        logic b;
        en0 = en_cnt;
        bit_tx(1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < v.ncov; i++) bit_tx(1'($urandom_range(1)), 1'b0, 1'b0, 1'b0);
        sb.push_back('{v.ok, v.err, v.len, v.word});
        crc_value = v.crc;
        for (int i = 0; i < 31; i++) begin
            b = v.word[31-i];
            bit_tx(b, 1'b0, 1'b0, i == 0);
            crc_value = $urandom;
            if (v.stuff_every > 0 && (i + 1) % v.stuff_every == 0) bit_tx(~b, 1'b1, 1'b0, 1'b0);
        end
        last_bit(v.word[0], v.ncov, en0);
        ack_result(v.ok, v.err);
    endtask

    vec_t vt[6];
    int   en0;

    initial begin
        vt[0] = '{10, 32'h1234ABCD, 32'h1234ABCD, 0,  1'b1, 1'b0, 1'b0};
        vt[1] = '{10, 32'h1234ABCD, 32'h1234ABCC, 0,  1'b0, 1'b1, 1'b0};
        vt[2] = '{10, 32'h1234ABCD, 32'h1234ABCD, 10, 1'b1, 1'b0, 1'b0};
        vt[3] = '{15, 32'hFFFFFFFF, 32'hFFFFFFFF, 5,  1'b1, 1'b0, 1'b0};
        vt[4] = '{0,  32'h00000000, 32'h00000000, 0,  1'b1, 1'b0, 1'b0};
        vt[5] = '{3,  32'h80000001, 32'h00000001, 0,  1'b0, 1'b1, 1'b0};

        repeat (2) @(posedge clk);
        #1;
        chk("rst_init", {31'b0, fcrc_init}, 32'd0);
        chk("rst_rv", {31'b0, result_valid}, 32'd0);
        chk("rst_ok_err", {30'b0, crc_ok, crc_err}, 32'd0);
        chk("rst_rx", rx_fcrc, 32'd0);
        g_rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 6; i++) run_frame(vt[i]);

        // Length error: 16 covered bits with no FCRC field.
        en0 = en_cnt;
        sb.push_back('{1'b0, 1'b1, 1'b1, 32'h0});
        bit_tx(1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 15; i++) bit_tx(1'b1, 1'b0, 1'b0, 1'b0);
        last_bit(1'b1, 16, en0);
        ack_result(1'b0, 1'b1);

        // Abort on RECV bit 20: back to IDLE with init, no result.
        bit_tx(1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) bit_tx(1'b0, 1'b0, 1'b0, 1'b0);
        crc_value = 32'hDEADBEEF;
        bit_tx(1'b1, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 18; i++) bit_tx(1'(i % 2), 1'b0, 1'b0, 1'b0);
        sample = 1'b1; rx_bit = 1'b1; frame_abort = 1'b1;
        @(posedge clk); #1;
        sample = 1'b0; frame_abort = 1'b0;
        chk("abort_init", {31'b0, fcrc_init}, 32'd1);
        repeat (40) @(posedge clk);
        #1;
        chk("abort_no_rv", {31'b0, result_valid}, 32'd0);
        run_frame(vt[0]);

        // Asynchronous reset in the middle of RECV.
        bit_tx(1'b0, 1'b0, 1'b1, 1'b0);
        bit_tx(1'b0, 1'b0, 1'b0, 1'b0);
        bit_tx(1'b1, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) bit_tx(1'b1, 1'b0, 1'b0, 1'b0);
        #2 g_rst = 1'b1;
        #1;
        chk("midrst_rx", rx_fcrc, 32'd0);
        chk("midrst_flags", {26'b0, fcrc_init, result_valid, crc_ok, crc_err, len_err, stuff_err}, 32'd0);
        @(posedge clk); #1;
        g_rst = 1'b0;
        @(posedge clk); #1;
        sample = 1'b1; sof = 1'b1;
        @(posedge clk); #1;
        sample = 1'b0; sof = 1'b0;
        chk("post_rst_init", {31'b0, fcrc_init}, 32'd1);
        @(posedge clk); #1;
        chk("init_one_cycle", {31'b0, fcrc_init}, 32'd0);
        frame_abort = 1'b1;
        @(posedge clk); #1;
        frame_abort = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        run_frame(vt[1]);

        chk("scoreboard_empty", sb.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
